cache_sel_arbiter: RTL and testbench

CACHE_SEL_ARBITER -- requirements
Module: cache_sel_arbiter

---
 rtl/cache_sel_arbiter.sv | 113 +++++++++++
 tb/tb_cache_sel_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_sel_arbiter.sv
// Round-robin arbiter issuing one drive pulse to a two-way cache selector,
// then waiting for completion or timing out.
module cache_sel_arbiter #(
  parameter int NREQ    = 4,
  parameter int TMO_CYC = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  i_req,
  input  logic [NREQ-1:0]  i_way,
  output logic [NREQ-1:0]  o_gnt,
  output logic             o_drive,
  output logic             o_valid0,
  output logic             o_valid1,
  input  logic             i_free,
  output logic             o_busy,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_grant_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT,
    ERR
  } state_t;

  state_t        state;
  logic [PW-1:0] last_ptr;
  logic [PW-1:0] winner;
  logic [PW-1:0] pick;
  logic          found;
  logic [15:0]   tmo_cnt;

  // Search begins just after the last served requester.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (int'(last_ptr) + i) % NREQ;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_ptr    <= PW'(NREQ - 1);
      winner      <= '0;
      tmo_cnt     <= '0;
      o_grant_cnt <= '0;
      o_timeout   <= 1'b0;
      o_gnt       <= '0;
      o_drive     <= 1'b0;
      o_valid0    <= 1'b0;
      o_valid1    <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state    <= DRIVE;
            winner   <= pick;
            o_gnt    <= NREQ'(1) << pick;
            o_drive  <= 1'b1;
            o_valid0 <= ~i_way[pick];
            o_valid1 <= i_way[pick];
            o_busy   <= 1'b1;
          end
        end
        DRIVE: begin
          state   <= WAIT;
          tmo_cnt <= '0;
          o_gnt   <= '0;
          o_drive <= 1'b0;
        end
        WAIT: begin
          // Completion wins over a timeout landing on the same cycle.
          if (i_free) begin
            state    <= IDLE;
            last_ptr <= winner;
            o_valid0 <= 1'b0;
            o_valid1 <= 1'b0;
            o_busy   <= 1'b0;
            if (o_grant_cnt != '1)
              o_grant_cnt <= o_grant_cnt + CNT_W'(1);
          end else if (tmo_cnt == 16'(TMO_CYC - 1)) begin
            state     <= ERR;
            o_timeout <= 1'b1;
            o_valid0  <= 1'b0;
            o_valid1  <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        ERR: begin
          state    <= IDLE;
          last_ptr <= winner;
          o_busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sel_arbiter.sv
// Directed bench for cache_sel_arbiter: grant flow, round-robin,
// timeout, free/timeout race, reset mid-WAIT and ignored inputs.
module tb_cache_sel_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  i_req;
  logic [3:0]  i_way;
  logic [3:0]  o_gnt;
  logic        o_drive;
  logic        o_valid0;
  logic        o_valid1;
  logic        i_free;
  logic        o_busy;
  logic        o_timeout;
  logic [15:0] o_grant_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cache_sel_arbiter #(
    .NREQ   (4),
    .TMO_CYC(4),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_way      (i_way),
    .o_gnt      (o_gnt),
    .o_drive    (o_drive),
    .o_valid0   (o_valid0),
    .o_valid1   (o_valid1),
    .i_free     (i_free),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout),
    .o_grant_cnt(o_grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_gnt"}, 32'(o_gnt), 32'h0);
    check({tag, "_drv"}, 32'(o_drive), 32'h0);
    check({tag, "_v0"}, 32'(o_valid0), 32'h0);
    check({tag, "_v1"}, 32'(o_valid1), 32'h0);
    check({tag, "_busy"}, 32'(o_busy), 32'h0);
  endtask

  initial begin
    rst    = 1'b1;
    i_req  = '0;
    i_way  = '0;
    i_free = 1'b0;
    tick();
    tick();
    check_idle_outs("rst");
    check("rst_cnt", 32'(o_grant_cnt), 32'd0);
    check("rst_tmo", 32'(o_timeout), 32'd0);

    // Single request to requester 2 on way1
    rst = 1'b0;
    tick();
    i_req = 4'b0100;
    i_way = 4'b0100;
    tick();
    check("s_drv", 32'(o_drive), 32'd1);
    check("s_gnt", 32'(o_gnt), 32'b0100);
    check("s_v1", 32'(o_valid1), 32'd1);
    check("s_v0", 32'(o_valid0), 32'd0);
    i_req = '0;
    tick();
    check("s_w_drv", 32'(o_drive), 32'd0);
    check("s_w_gnt", 32'(o_gnt), 32'd0);
    check("s_w_v1", 32'(o_valid1), 32'd1);
    check("s_w_busy", 32'(o_busy), 32'd1);
    tick();
    tick();
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    check_idle_outs("s_done");
    check("s_cnt", 32'(o_grant_cnt), 32'd1);

    // Round-robin from a fresh reset: 0,1,2,3,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_rst_cnt", 32'(o_grant_cnt), 32'd0);
    i_req = 4'b1111;
    i_way = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr_gnt%0d", k), 32'(o_gnt), 32'(4'b0001 << (k % 4)));
      check($sformatf("rr_v0_%0d", k), 32'(o_valid0), 32'd1);
      tick();
      tick();
      i_free = 1'b1;
      tick();
      i_free = 1'b0;
    end
    i_req = '0;
    check("rr_cnt", 32'(o_grant_cnt), 32'd5);

    // Ignored inputs: free in IDLE, free in DRIVE, req/way change in WAIT
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    check("ig_idle_busy", 32'(o_busy), 32'd0);
    check("ig_idle_cnt", 32'(o_grant_cnt), 32'd5);
    i_req = 4'b0010;
    i_way = 4'b0010;
    tick();
    check("ig_gnt", 32'(o_gnt), 32'b0010);
    i_free = 1'b1;
    i_req  = 4'b1000;
    tick();
    i_free = 1'b0;
    check("ig_drv_busy", 32'(o_busy), 32'd1);
    check("ig_drv_cnt", 32'(o_grant_cnt), 32'd5);
    check("ig_drv_gnt", 32'(o_gnt), 32'd0);
    i_req = 4'b0101;
    i_way = 4'b0000;
    tick();
    check("ig_w_v1", 32'(o_valid1), 32'd1);
    check("ig_w_gnt", 32'(o_gnt), 32'd0);
    check("ig_w_busy", 32'(o_busy), 32'd1);
    i_req  = '0;
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    check("ig_cnt", 32'(o_grant_cnt), 32'd6);

    // Timeout: last_ptr=1, request 2 on way0, never freed
    i_req = 4'b0100;
    i_way = 4'b0000;
    tick();
    check("to_gnt", 32'(o_gnt), 32'b0100);
    check("to_v0", 32'(o_valid0), 32'd1);
    i_req = '0;
    repeat (4) tick();
    check("to_wait_busy", 32'(o_busy), 32'd1);
    check("to_wait_tmo", 32'(o_timeout), 32'd0);
    check("to_wait_v0", 32'(o_valid0), 32'd1);
    tick();
    check("to_err_tmo", 32'(o_timeout), 32'd1);
    check("to_err_busy", 32'(o_busy), 32'd1);
    check("to_err_v0", 32'(o_valid0), 32'd0);
    tick();
    check("to_idle_busy", 32'(o_busy), 32'd0);
    check("to_idle_tmo", 32'(o_timeout), 32'd1);
    check("to_idle_cnt", 32'(o_grant_cnt), 32'd6);
    i_req = 4'b0001;
    tick();
    check("to_next_gnt", 32'(o_gnt), 32'b0001);
    i_req = '0;
    tick();
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    check("to_next_cnt", 32'(o_grant_cnt), 32'd7);
    check("to_sticky", 32'(o_timeout), 32'd1);

    // Free on the same cycle the timeout count is reached
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("race_rst_tmo", 32'(o_timeout), 32'd0);
    i_req = 4'b1000;
    i_way = 4'b1000;
    tick();
    check("race_gnt", 32'(o_gnt), 32'b1000);
    i_req = '0;
    repeat (4) tick();
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    check("race_busy", 32'(o_busy), 32'd0);
    check("race_tmo", 32'(o_timeout), 32'd0);
    check("race_cnt", 32'(o_grant_cnt), 32'd1);

    // Reset in the middle of WAIT
    i_req = 4'b0001;
    i_way = 4'b0001;
    tick();
    check("rw_gnt", 32'(o_gnt), 32'b0001);
    i_req = '0;
    tick();
    tick();
    check("rw_busy", 32'(o_busy), 32'd1);
    rst = 1'b1;
    tick();
    check_idle_outs("rw_rst");
    check("rw_rst_cnt", 32'(o_grant_cnt), 32'd0);
    check("rw_rst_tmo", 32'(o_timeout), 32'd0);
    rst    = 1'b0;
    i_free = 1'b1;
    tick();
    i_free = 1'b0;
    check_idle_outs("rw_free");
    check("rw_free_cnt", 32'(o_grant_cnt), 32'd0);
    i_req = 4'b1010;
    i_way = 4'b0000;
    tick();
    check("rw_gnt1", 32'(o_gnt), 32'b0010);
    check("rw_drv1", 32'(o_drive), 32'd1);
    i_req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
